// File: rtl/dmem_pkg.sv
// ============================================================================
// Module      : dmem_pkg
// Description : Shared encodings and constants for the data-memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_pkg;

   localparam logic [1:0] SZ_BYTE    = 2'b00;
   localparam logic [1:0] SZ_HALF    = 2'b01;
   localparam logic [1:0] SZ_WORD    = 2'b10;
   localparam logic [1:0] SZ_ILLEGAL = 2'b11;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   localparam int MAX_LATENCY = 15;
   localparam int CNT_W       = 4;

   // Out-of-range latencies collapse to the single-edge case.
   function automatic int eff_latency(input int lat);
      return ((lat < 1) || (lat > MAX_LATENCY)) ? 1 : lat;
   endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_lane_align.sv
// ============================================================================
// Module      : dmem_lane_align
// Description : Byte-lane steering for stores and extension for loads.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [1:0]  size_i,
   input  logic        signed_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rword_i,
   output logic [3:0]  be_o,
   output logic [31:0] wword_o,
   output logic [31:0] rdata_o,
   output logic        misalign_o
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      be_o       = 4'b0000;
      wword_o    = '0;
      rdata_o    = '0;
      misalign_o = 1'b0;
      w_byte     = rword_i[{addr_lo_i, 3'b000} +: 8];
      w_half     = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];
      case (size_i)
         SZ_BYTE: begin
            be_o    = 4'b0001 << addr_lo_i;
            wword_o = {4{wdata_i[7:0]}};
            rdata_o = {{24{signed_i & w_byte[7]}}, w_byte};
         end
         SZ_HALF: begin
            misalign_o = addr_lo_i[0];
            be_o       = addr_lo_i[1] ? 4'b1100 : 4'b0011;
            wword_o    = {2{wdata_i[15:0]}};
            rdata_o    = {{16{signed_i & w_half[15]}}, w_half};
         end
         SZ_WORD: begin
            misalign_o = |addr_lo_i;
            be_o       = 4'b1111;
            wword_o    = wdata_i;
            rdata_o    = rword_i;
         end
         default: begin
            be_o = 4'b0000;
         end
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// ============================================================================
// Module      : dmem_responder
// Description : Fixed-latency word-array responder with pipeline stall output.
//               Optional performance counters under DMEM_PERF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
)(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_write_i,
   input  logic [1:0]  req_size_i,
   input  logic        req_signed_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   output logic        resp_valid_o,
   output logic [31:0] resp_rdata_o,
   output logic        resp_error_o,
   output logic        stall_o
`ifdef DMEM_PERF_CNT_EN
   ,
   output logic [31:0] perf_loads_o,
   output logic [31:0] perf_stores_o,
   output logic [31:0] perf_errors_o,
   output logic [31:0] perf_stallcycles_o
`endif
);

   localparam int              EFF_LATENCY = eff_latency(LATENCY);
   localparam logic [CNT_W-1:0] CNT_INIT   = CNT_W'(EFF_LATENCY - 1);
   localparam int              IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             write_q, signed_q;
   logic [1:0]       size_q;
   logic [31:0]      addr_q, wdata_q;
   logic [31:0]      rdata_q;
   logic             err_q;
   logic [31:0]      mem_q [DEPTH_WORDS];

   logic             w_accept, w_enter_resp, w_stall_raw;
   logic             w_cur_write, w_cur_signed;
   logic [1:0]       w_cur_size;
   logic [31:0]      w_cur_addr, w_cur_wdata;
   logic [IDX_W-1:0] w_idx;
   logic             w_oor, w_misalign, w_err;
   logic [31:0]      w_rword, w_wword, w_load;
   logic [3:0]       w_be;

   assign w_accept     = (state_q == ST_IDLE) && req_valid_i;
   assign w_enter_resp = (state_d == ST_RESP) && (state_q != ST_RESP);

   // With LATENCY=1 the access completes on the accepting edge, before the latches load.
   assign w_cur_write  = (state_q == ST_IDLE) ? req_write_i  : write_q;
   assign w_cur_size   = (state_q == ST_IDLE) ? req_size_i   : size_q;
   assign w_cur_signed = (state_q == ST_IDLE) ? req_signed_i : signed_q;
   assign w_cur_addr   = (state_q == ST_IDLE) ? req_addr_i   : addr_q;
   assign w_cur_wdata  = (state_q == ST_IDLE) ? req_wdata_i  : wdata_q;

   assign w_idx   = w_cur_addr[IDX_W+1:2];
   assign w_oor   = {2'b00, w_cur_addr[31:2]} >= 32'(DEPTH_WORDS);
   assign w_rword = w_oor ? '0 : mem_q[w_idx];
   assign w_err   = w_misalign | (w_cur_size == SZ_ILLEGAL) | w_oor;

   dmem_lane_align u_lane_align (
      .size_i     (w_cur_size),
      .signed_i   (w_cur_signed),
      .addr_lo_i  (w_cur_addr[1:0]),
      .wdata_i    (w_cur_wdata),
      .rword_i    (w_rword),
      .be_o       (w_be),
      .wword_o    (w_wword),
      .rdata_o    (w_load),
      .misalign_o (w_misalign)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid_i) begin
               if (EFF_LATENCY == 1) begin
                  state_d = ST_RESP;
                  cnt_d   = '0;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = CNT_INIT;
               end
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      w_stall_raw  = ((state_q == ST_IDLE) && req_valid_i) || (state_q == ST_WAIT);
      req_ready_o  = (state_q == ST_IDLE);
      resp_valid_o = (state_q == ST_RESP);
      stall_o      = rst_ni && w_stall_raw;
      resp_rdata_o = rdata_q;
      resp_error_o = err_q;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         write_q  <= 1'b0;
         signed_q <= 1'b0;
         size_q   <= SZ_BYTE;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         if (w_accept) begin
            write_q  <= req_write_i;
            signed_q <= req_signed_i;
            size_q   <= req_size_i;
            addr_q   <= req_addr_i;
            wdata_q  <= req_wdata_i;
         end
         if (w_enter_resp) begin
            rdata_q <= (w_err || w_cur_write) ? '0 : w_load;
            err_q   <= w_err;
         end else if (state_q == ST_RESP) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
         end
      end
   end

   // The array carries no reset; contents survive a reset pulse.
   always_ff @(posedge clk_i) begin
      if (w_enter_resp && w_cur_write && !w_err) begin
         for (int i = 0; i < 4; i++) begin
            if (w_be[i]) begin
               mem_q[w_idx][8*i +: 8] <= w_wword[8*i +: 8];
            end
         end
      end
   end

`ifdef DMEM_PERF_CNT_EN
   logic [31:0] perf_loads_q, perf_stores_q, perf_errors_q, perf_stall_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         perf_loads_q  <= '0;
         perf_stores_q <= '0;
         perf_errors_q <= '0;
         perf_stall_q  <= '0;
      end else begin
         if (state_q == ST_RESP) begin
            if (err_q) begin
               perf_errors_q <= perf_errors_q + 32'd1;
            end else if (write_q) begin
               perf_stores_q <= perf_stores_q + 32'd1;
            end else begin
               perf_loads_q <= perf_loads_q + 32'd1;
            end
         end
         if (w_stall_raw) begin
            perf_stall_q <= perf_stall_q + 32'd1;
         end
      end
   end

   assign perf_loads_o       = perf_loads_q;
   assign perf_stores_o      = perf_stores_q;
   assign perf_errors_o      = perf_errors_q;
   assign perf_stallcycles_o = perf_stall_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ============================================================================
// Module      : tb_dmem_responder
// Description : Self-checking bench for dmem_responder at latencies 2, 4, 1.
//               Perf counters checked when DMEM_PERF_CNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_responder;

   localparam int N     = 3;
   localparam int DEPTH = 1024;
   localparam int LAT0  = 2;
   localparam int LAT1  = 4;
   localparam int LAT2  = 1;

   function automatic int lat_of(input int k);
      return (k == 0) ? LAT0 : ((k == 1) ? LAT1 : LAT2);
   endfunction

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic [N-1:0] req_valid, req_ready, req_write, req_signed, resp_valid, resp_error, stall;
   logic [1:0]   req_size  [N];
   logic [31:0]  req_addr  [N];
   logic [31:0]  req_wdata [N];
   logic [31:0]  resp_rdata[N];
`ifdef DMEM_PERF_CNT_EN
   logic [31:0]  perf_loads[N], perf_stores[N], perf_errors[N], perf_stalls[N];
`endif

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < N; g++) begin : g_dut
      dmem_responder #(
         .DEPTH_WORDS (DEPTH),
         .LATENCY     ((g == 0) ? LAT0 : ((g == 1) ? LAT1 : LAT2))
      ) u_dut (
         .clk_i        (clk),
         .rst_ni       (rst_n),
         .req_valid_i  (req_valid[g]),
         .req_ready_o  (req_ready[g]),
         .req_write_i  (req_write[g]),
         .req_size_i   (req_size[g]),
         .req_signed_i (req_signed[g]),
         .req_addr_i   (req_addr[g]),
         .req_wdata_i  (req_wdata[g]),
         .resp_valid_o (resp_valid[g]),
         .resp_rdata_o (resp_rdata[g]),
         .resp_error_o (resp_error[g]),
         .stall_o      (stall[g])
`ifdef DMEM_PERF_CNT_EN
         ,
         .perf_loads_o       (perf_loads[g]),
         .perf_stores_o      (perf_stores[g]),
         .perf_errors_o      (perf_errors[g]),
         .perf_stallcycles_o (perf_stalls[g])
`endif
      );
   end

   int n_cmp = 0;
   int n_bad = 0;

   function automatic void chk(input string name, input int k, input logic [31:0] act,
                               input logic [31:0] exp, input logic [31:0] mask = 32'hFFFF_FFFF);
      n_cmp++;
      if (((act ^ exp) & mask) !== 32'h0) begin
         n_bad++;
         $display("FAIL %s [inst%0d] t=%0t: got %h, expected %h (mask %h)", name, k, $time, act, exp, mask);
      end
   endfunction

   // Reference model: per-instance byte array plus a queue of accepted requests.
   typedef struct {
      bit        w;
      bit [1:0]  sz;
      bit        sg;
      bit [31:0] addr;
      bit [31:0] wd;
      int        due;
   } req_t;

   req_t       pend [N][$];
   bit [31:0]  mm   [N][DEPTH];
   bit [3:0]   kn   [N][DEPTH];
   int         resp_cnt[N];
   logic [31:0] last_rdata[N];
   logic       last_err[N];
   int         last_cyc[N];
   int         stall_seen[N];
   bit         ready_hist[N][$];
   int         m_loads[N], m_stores[N], m_errs[N], m_stalls[N];

   function automatic void model_exec(input int k, input req_t r, output bit [31:0] rd,
                                      output bit err, output bit [31:0] mask);
      int idx, nb, a, lane;
      bit [31:0] v, m;
      a   = int'(r.addr[1:0]);
      idx = int'(r.addr[31:2]);
      nb  = (r.sz == 2'd0) ? 1 : ((r.sz == 2'd1) ? 2 : 4);
      err = (r.sz == 2'd3) || ((a % nb) != 0) || (idx >= DEPTH);
      rd   = 32'h0;
      mask = 32'hFFFF_FFFF;
      if (err) begin
         m_errs[k]++;
         return;
      end
      if (r.w) begin
         m_stores[k]++;
         for (int b = 0; b < nb; b++) begin
            lane = a + b;
            mm[k][idx][8*lane +: 8] = r.wd[8*b +: 8];
            kn[k][idx][lane] = 1'b1;
         end
         return;
      end
      m_loads[k]++;
      v = 32'h0;
      m = 32'h0;
      for (int b = 0; b < nb; b++) begin
         lane = a + b;
         v[8*b +: 8] = mm[k][idx][8*lane +: 8];
         if (kn[k][idx][lane]) m[8*b +: 8] = 8'hFF;
      end
      if (nb < 4) begin
         if (r.sg && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
         if (!r.sg || m[8*nb-1]) m = m | (32'hFFFF_FFFF << (8*nb));
      end
      rd   = v;
      mask = m;
   endfunction

   always @(negedge clk) begin
      for (int k = 0; k < N; k++) begin
         bit ev, eb, es, eerr;
         bit [31:0] erd, emask;
         req_t r;
         ev = 1'b0;
         eb = 1'b0;
         if (rst_n && pend[k].size() != 0) begin
            if (cyc == pend[k][0].due) ev = 1'b1;
            else if (cyc < pend[k][0].due) eb = 1'b1;
         end
         es = rst_n && (eb || (!ev && !eb && req_valid[k]));
         chk("resp_valid", k, 32'(resp_valid[k]), 32'(ev));
         chk("req_ready", k, 32'(req_ready[k]), 32'(!(ev || eb)));
         chk("stall", k, 32'(stall[k]), 32'(es));
         ready_hist[k].push_back(req_ready[k]);
         if (es) begin
            stall_seen[k]++;
            m_stalls[k]++;
         end
         if (ev) begin
            r = pend[k].pop_front();
            model_exec(k, r, erd, eerr, emask);
            chk("resp_error", k, 32'(resp_error[k]), 32'(eerr));
            chk("resp_rdata", k, resp_rdata[k], erd, emask);
            last_rdata[k] = resp_rdata[k];
            last_err[k]   = resp_error[k];
            last_cyc[k]   = cyc;
            resp_cnt[k]++;
         end
         if (!rst_n) begin
            chk("reset_rdata", k, resp_rdata[k], 32'h0);
            chk("reset_error", k, 32'(resp_error[k]), 32'h0);
         end
      end
   end

   task automatic issue(input int k, input bit w, input bit [1:0] sz, input bit sg,
                        input bit [31:0] addr, input bit [31:0] wd, output int acc);
      req_t r;
      bit   rdy;
      int   guard;
      req_valid[k]  = 1'b1;
      req_write[k]  = w;
      req_size[k]   = sz;
      req_signed[k] = sg;
      req_addr[k]   = addr;
      req_wdata[k]  = wd;
      guard = 0;
      rdy   = 1'b0;
      while (!rdy && guard < 50) begin
         @(negedge clk);
         rdy = req_ready[k];
         @(posedge clk);
         #2;
         guard++;
      end
      acc = cyc;
      if (!rdy) begin
         chk("accept_timeout", k, 32'(rdy), 32'h1);
         req_valid[k] = 1'b0;
         return;
      end
      r = '{w, sz, sg, addr, wd, cyc + lat_of(k) - 1};
      pend[k].push_back(r);
   endtask

   task automatic wait_resp(input int k, input int n);
      int g;
      g = 0;
      while (resp_cnt[k] < n && g < 100) begin
         @(posedge clk);
         #2;
         g++;
      end
      chk("resp_timeout", k, 32'(resp_cnt[k]), 32'(n));
   endtask

   task automatic txn(input int k, input bit w, input bit [1:0] sz, input bit sg,
                      input bit [31:0] addr, input bit [31:0] wd, output int acc);
      int n;
      n = resp_cnt[k] + 1;
      issue(k, w, sz, sg, addr, wd, acc);
      req_valid[k] = 1'b0;
      wait_resp(k, n);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      for (int k = 0; k < N; k++) begin
         pend[k].delete();
         m_loads[k]  = 0;
         m_stores[k] = 0;
         m_errs[k]   = 0;
         m_stalls[k] = 0;
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc, n0;
      bit pat [4];
      req_valid  = '0;
      req_write  = '0;
      req_signed = '0;
      for (int k = 0; k < N; k++) begin
         req_size[k]  = 2'b00;
         req_addr[k]  = 32'h0;
         req_wdata[k] = 32'h0;
      end
      do_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", 0, 32'(req_ready[0]), 32'h1);
      chk("rst_valid", 0, 32'(resp_valid[0]), 32'h0);
      chk("rst_stall", 0, 32'(stall[0]), 32'h0);
      chk("rst_rdata", 0, resp_rdata[0], 32'h0);
      #1;
      rst_n = 1'b1;

      // LATENCY=2 directed sequence
      stall_seen[0] = 0;
      txn(0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, acc);
      chk("sw_edges", 0, 32'(last_cyc[0] - acc + 1), 32'd2);
      chk("sw_stall_cycles", 0, 32'(stall_seen[0]), 32'd2);
      stall_seen[0] = 0;
      txn(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, acc);
      chk("lw_10", 0, last_rdata[0], 32'hDEADBEEF);
      chk("lw_10_err", 0, 32'(last_err[0]), 32'h0);
      chk("lw_edges", 0, 32'(last_cyc[0] - acc + 1), 32'd2);
      chk("lw_stall_cycles", 0, 32'(stall_seen[0]), 32'd2);
      txn(0, 1'b1, 2'b00, 1'b0, 32'h11, 32'h0000007F, acc);
      txn(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, acc);
      chk("lw_after_sb", 0, last_rdata[0], 32'hDEAD7FEF);
      txn(0, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, acc);
      chk("lbu_13", 0, last_rdata[0], 32'h000000DE);
      txn(0, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, acc);
      chk("lb_13", 0, last_rdata[0], 32'hFFFFFFDE);
      txn(0, 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, acc);
      chk("lh_12", 0, last_rdata[0], 32'hFFFFDEAD);
      txn(0, 1'b0, 2'b01, 1'b0, 32'h10, 32'h0, acc);
      chk("lhu_10", 0, last_rdata[0], 32'h00007FEF);
      txn(0, 1'b0, 2'b01, 1'b1, 32'h11, 32'h0, acc);
      chk("lh_11_err", 0, 32'(last_err[0]), 32'h1);
      chk("lh_11_rdata", 0, last_rdata[0], 32'h0);
      txn(0, 1'b0, 2'b10, 1'b0, 32'h12, 32'h0, acc);
      chk("lw_12_err", 0, 32'(last_err[0]), 32'h1);
      chk("lw_12_rdata", 0, last_rdata[0], 32'h0);
      txn(0, 1'b1, 2'b10, 1'b0, 32'h14, 32'hCAFEF00D, acc);
      txn(0, 1'b1, 2'b10, 1'b0, 32'h16, 32'h12345678, acc);
      chk("sw_16_err", 0, 32'(last_err[0]), 32'h1);
      txn(0, 1'b0, 2'b10, 1'b0, 32'h14, 32'h0, acc);
      chk("lw_14_unchanged", 0, last_rdata[0], 32'hCAFEF00D);
      txn(0, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, acc);
      chk("size11_err", 0, 32'(last_err[0]), 32'h1);
      txn(0, 1'b0, 2'b10, 1'b0, 32'h0000_1000, 32'h0, acc);
      chk("lw_1000_err", 0, 32'(last_err[0]), 32'h1);
      txn(0, 1'b0, 2'b10, 1'b0, 32'h0000_0FFC, 32'h0, acc);
      chk("lw_ffc_err", 0, 32'(last_err[0]), 32'h0);

      // LATENCY=4 reset during WAIT
      txn(1, 1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, acc);
      issue(1, 1'b1, 2'b10, 1'b0, 32'h20, 32'hAAAAAAAA, acc);
      req_valid[1] = 1'b0;
      @(posedge clk);
      #2;
      do_reset();
      #1;
      chk("midrst_ready", 1, 32'(req_ready[1]), 32'h1);
      chk("midrst_valid", 1, 32'(resp_valid[1]), 32'h0);
      chk("midrst_stall", 1, 32'(stall[1]), 32'h0);
      chk("midrst_rdata", 1, resp_rdata[1], 32'h0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      txn(1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, acc);
      chk("lw_20_after_rst", 1, last_rdata[1], 32'h11223344);

      // LATENCY=1 back-to-back with Req_Valid held
      ready_hist[2].delete();
      n0 = resp_cnt[2];
      issue(2, 1'b1, 2'b10, 1'b0, 32'h30, 32'h5A5AA5A5, acc);
      issue(2, 1'b0, 2'b10, 1'b0, 32'h30, 32'h0, acc);
      req_valid[2] = 1'b0;
      wait_resp(2, n0 + 2);
      pat = '{1'b1, 1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 4; i++) begin
         chk("b2b_ready_pattern", 2, 32'(ready_hist[2][i]), 32'(pat[i]));
      end
      chk("b2b_lw_30", 2, last_rdata[2], 32'h5A5AA5A5);

      // Randomized traffic on every instance
      for (int k = 0; k < N; k++) begin
         for (int t = 0; t < 150; t++) begin
            bit        w, sg;
            bit [1:0]  sz;
            bit [31:0] addr;
            w    = 1'($urandom_range(0, 1));
            sg   = 1'($urandom_range(0, 1));
            sz   = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            addr = ($urandom_range(0, 15) == 0) ? 32'h0FF8 + 32'($urandom_range(0, 15))
                                                : 32'($urandom_range(0, 63));
            issue(k, w, sz, sg, addr, $urandom, acc);
            if ($urandom_range(0, 2) != 0) begin
               req_valid[k] = 1'b0;
               repeat ($urandom_range(0, 2)) begin
                  @(posedge clk);
                  #2;
               end
            end
         end
         req_valid[k] = 1'b0;
         wait_resp(k, resp_cnt[k] + pend[k].size());
      end

      repeat (4) @(posedge clk);
      #2;
`ifdef DMEM_PERF_CNT_EN
      for (int k = 0; k < N; k++) begin
         chk("perf_loads", k, perf_loads[k], 32'(m_loads[k]));
         chk("perf_stores", k, perf_stores[k], 32'(m_stores[k]));
         chk("perf_errors", k, perf_errors[k], 32'(m_errs[k]));
         chk("perf_stalls", k, perf_stalls[k], 32'(m_stalls[k]));
      end
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
